// File: rtl/stage_sequencer.sv
// N-stage instruction sequencer: enabled stages in ascending order, per-stage repeats (STAGE_SEQ_REPEAT_EN), TX command gating, imm16 prefetch.
// inst_done is combinational with the final op_done or an IDLE skip; hold only masks op_valid/tx_command_valid, never state.
module stage_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int REPEAT_BITS = 3,
  localparam int SB = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_inst_valid,
  output logic                              o_inst_done,
  input  logic                              i_skip,
  input  logic                              i_need_imm16,
  input  logic                              i_imm16_loaded,
  output logic                              o_load_imm16,
  input  logic [NUM_STAGES-1:0]             i_stage_en,
  input  logic [NUM_STAGES-1:0]             i_stage_cmd,
  input  logic [NUM_STAGES*REPEAT_BITS-1:0] i_stage_repeat,
  input  logic                              i_hold,
  output logic                              o_op_valid,
  input  logic                              i_op_done,
  output logic [SB-1:0]                     o_stage,
  output logic [REPEAT_BITS-1:0]            o_iteration,
  output logic                              o_last_pass,
  output logic                              o_tx_command_valid,
  input  logic                              i_tx_command_started,
  input  logic                              i_tx_data_next,
  output logic                              o_command_active
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IMM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]             r_state;
  logic [SB-1:0]          r_stage;
  logic                   r_cmd_active;
  logic                   r_imm16_avail;
  logic [REPEAT_BITS-1:0] w_iteration;
  logic [REPEAT_BITS-1:0] w_cur_repeat;
  logic [SB-1:0]          w_lowest;
  logic [SB-1:0]          w_next_stage;
  logic                   w_next_exists;
  logic                   w_cur_cmd;
  logic                   w_run;
  logic                   w_stage_final;
  logic                   w_finish;
  logic                   w_idle_skip;
  logic                   w_imm_pending;
  logic                   w_tx_cmd_valid;

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    w_lowest      = '0;
    w_next_stage  = '0;
    w_next_exists = 1'b0;
    w_cur_cmd     = 1'b0;
    w_cur_repeat  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (i_stage_en[k]) begin
        w_lowest = SB'(k);
      end
      if (i_stage_en[k] && (k > int'(r_stage))) begin
        w_next_stage  = SB'(k);
        w_next_exists = 1'b1;
      end
      if (SB'(k) == r_stage) begin
        w_cur_cmd    = i_stage_cmd[k];
        w_cur_repeat = i_stage_repeat[k*REPEAT_BITS +: REPEAT_BITS];
      end
    end
  end

  assign w_run          = (r_state == S_RUN);
  assign w_imm_pending  = i_need_imm16 && !r_imm16_avail;
  assign w_tx_cmd_valid = w_run && !i_hold && w_cur_cmd && !r_cmd_active;
  assign w_finish       = w_run && i_op_done && w_stage_final && !w_next_exists;
  assign w_idle_skip    = (r_state == S_IDLE) && i_inst_valid && !w_imm_pending &&
                          (i_skip || (i_stage_en == '0));

  assign o_inst_done        = !i_reset && (w_finish || w_idle_skip);
  assign o_load_imm16       = (r_state == S_IMM);
  assign o_tx_command_valid = w_tx_cmd_valid;
  assign o_op_valid         = w_run && !i_hold && (!w_cur_cmd || (r_cmd_active && i_tx_data_next));
  assign o_last_pass        = w_run && !w_next_exists && w_stage_final;
  assign o_stage            = r_stage;
  assign o_iteration        = w_iteration;
  assign o_command_active   = r_cmd_active;

`ifdef STAGE_SEQ_REPEAT_EN
  logic [REPEAT_BITS-1:0] r_iteration;

  assign w_stage_final = !(r_iteration < w_cur_repeat);
  assign w_iteration   = r_iteration;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_iteration <= '0;
    end else if (!w_run) begin
      r_iteration <= '0;
    end else if (i_op_done) begin
      r_iteration <= w_stage_final ? '0 : r_iteration + REPEAT_BITS'(1);
    end
  end
`else
  logic w_unused_repeat;

  assign w_unused_repeat = ^w_cur_repeat;
  assign w_stage_final   = 1'b1;
  assign w_iteration     = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_stage       <= '0;
      r_imm16_avail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_inst_valid) begin
            if (w_imm_pending) begin
              r_state <= S_IMM;
            end else if (i_skip || (i_stage_en == '0)) begin
              r_imm16_avail <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_stage <= w_lowest;
            end
          end
        end
        S_IMM: begin
          if (i_imm16_loaded) begin
            r_imm16_avail <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_RUN: begin
          if (i_op_done && w_stage_final) begin
            if (w_next_exists) begin
              r_stage <= w_next_stage;
            end else begin
              r_state       <= S_IDLE;
              r_stage       <= '0;
              r_imm16_avail <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // op_done wins over a same-cycle command start.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_active <= 1'b0;
    end else if (w_run && i_op_done) begin
      r_cmd_active <= 1'b0;
    end else if (i_tx_command_started && w_tx_cmd_valid) begin
      r_cmd_active <= 1'b1;
    end
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised instruction stage sequencer for the serial CPU core. It generalises the fixed address/data/rotate stage progression into an N-stage engine with per-stage enables, per-stage repeat counts and per-stage TX command sending. It sits between the decoder, which holds the instruction parameters stable, and the ALU/TX/RX/imm16 interfaces. It also owns imm16 prefetch gating, condition-skip completion and command-active tracking.

## Interface
Parameters:
- NUM_STAGES, 4: number of stages; stage index width SB = $clog2(NUM_STAGES), minimum 1.
- REPEAT_BITS, 3: width of each per-stage repeat count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_valid  in  1  instruction present; inputs stable until inst_done.
- inst_done  out  1  one-cycle pulse; instruction finished or skipped.
- skip  in  1  condition failed or no-op; completes the instruction without executing.
- need_imm16  in  1  instruction uses an imm16 operand.
- imm16_loaded  in  1  pulse; imm16 captured by the prefetcher.
- load_imm16  out  1  request an imm16 load.
- stage_en  in  NUM_STAGES  per-stage enable; disabled stages are skipped.
- stage_cmd  in  NUM_STAGES  stage sends a TX command.
- stage_repeat  in  NUM_STAGES*REPEAT_BITS  extra passes per stage; stage k uses bits [k*REPEAT_BITS +: REPEAT_BITS].
- hold  in  1  external wait (pc busy, RX data not yet valid).
- op_valid  out  1  ALU enable.
- op_done  in  1  ALU finished the current pass.
- stage  out  SB  current stage index.
- iteration  out  REPEAT_BITS  current pass number within the stage.
- last_pass  out  1  current pass is the final pass of the final enabled stage.
- tx_command_valid  out  1  request to start a TX command.
- tx_command_started  in  1  TX accepted this sequencer's command.
- tx_data_next  in  1  TX consumes a payload symbol this cycle.
- command_active  out  1  this stage's command has been started.

## Operation
- States: IDLE, IMM, RUN.
- IDLE:
  - inst_valid && need_imm16 && !imm16_avail → IMM.
  - Otherwise, if inst_valid && (skip || stage_en==0) → pulse inst_done and stay in IDLE.
  - Otherwise, if inst_valid → RUN, with stage = lowest enabled index and iteration = 0.
- IMM:
  - load_imm16 = 1.
  - On imm16_loaded, set imm16_avail and return to IDLE evaluation the next cycle.
  - skip is ignored until imm16 is available.
- imm16_avail is cleared on reset or inst_done.
- RUN:
  - op_valid = !hold && (!stage_cmd[stage] || (command_active && tx_data_next)).
  - tx_command_valid = !hold && stage_cmd[stage] && !command_active.
  - command_active is set on tx_command_started and cleared on op_done or reset. tx_command_started while tx_command_valid is low is ignored.
- On op_done:
  - If iteration < stage_repeat[stage], then iteration++.
  - Else advance to the next higher enabled stage with iteration = 0.
  - If no higher enabled stage exists, pulse inst_done and go to IDLE with stage = 0.
- last_pass = RUN && no higher enabled stage && iteration == stage_repeat[stage].
- All counters are unsigned; iteration never wraps because it is bounded by stage_repeat.

## Timing
- Reset values: state IDLE, stage 0, iteration 0, command_active 0, imm16_avail 0. All outputs are 0.
- inst_done is combinational:
  - In the same cycle as the final op_done.
  - In the same IDLE cycle as skip or empty stage_en, when no imm16 is pending.
- Stage and iteration update on the clock edge after op_done. The new stage's op_valid can assert one cycle after the previous op_done.
- Minimum instruction latency: 1 cycle for skip, 2 cycles for a single stage with op_done in its first RUN cycle.
- Simultaneous tx_command_started and op_done: command_active ends at 0.
- hold high freezes op_valid and tx_command_valid but never state.
- Reset mid-instruction aborts to IDLE in the next cycle with no inst_done.

## Configuration
- STAGE_SEQ_REPEAT_EN defined:
  - stage_repeat is honoured.
  - iteration register is present.
- Not defined:
  - stage_repeat is ignored; each enabled stage runs exactly once.
  - iteration is tied to 0.
  - last_pass depends only on the stage.

## Test plan
- stage_en=4'b0101, no cmds, op_done on every RUN cycle → stage 0, then 2; inst_done coincides with the second op_done.
- stage_repeat for stage 1 = 2, stage_en=4'b0010 → three passes with iteration 0,1,2; last_pass high on pass 2 only (repeat-enabled build). Macro undefined → one pass.
- need_imm16=1, skip=1 → load_imm16 high until imm16_loaded; inst_done the following cycle; imm16_avail cleared after it.
- stage_cmd[0]=1, tx_command_started 3 cycles later → tx_command_valid high for 3 cycles; op_valid only when command_active && tx_data_next; command_active 0 after op_done.
- hold toggled during RUN → op_valid and tx_command_valid track !hold; stage unchanged.
- Reset asserted in stage 2 with iteration 1 → all outputs 0 next cycle; no inst_done; the next instruction starts at its lowest enabled stage.
